ahb_master_arbiter: RTL

- AHB-Lite bus arbiter that shares one AHB-Lite fabric (decoder + `ahb_mux` response path) between up to NO_OF_MASTERS masters.
- Round-robin grant; never splits a fixed-length burst or a locked sequence.
- Drives HGRANT to the masters, and HMASTER/HMASTLOCK to the address/write-data muxes.
- Sits between the master ports and the shared address/control mux; uses the same HREADY that `ahb_mux` returns.

---
 rtl/ahb_pkg.sv | 29 ++
 rtl/ahb_master_arbiter_rr_priority_picker.sv | 29 ++
 rtl/ahb_master_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer/burst encodings and burst-length helper
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    // Remaining SEQ beats after the NONSEQ; undefined-length INCR counts as single
    function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
        return (hburst == INCR16 || hburst == WRAP16) ? 4'd15 :
               (hburst == INCR8  || hburst == WRAP8)  ? 4'd7  :
               (hburst == INCR4  || hburst == WRAP4)  ? 4'd3  : 4'd0;
    endfunction

endpackage

// File: rtl/ahb_master_arbiter_rr_priority_picker.sv
// rr_priority_picker: first requester after ptr in round-robin order, wrapping
module rr_priority_picker
    import ahb_pkg::*;
#(
    parameter int N      = 4,
    parameter int M_BITS = $clog2(N)
) (
    input  logic [N-1:0]      req,
    input  logic [M_BITS-1:0] ptr,
    output logic              found,
    output logic [M_BITS-1:0] idx
);

    logic [M_BITS-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = M_BITS'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: round-robin AHB-Lite bus arbiter that never splits a
// fixed-length burst or a locked sequence; grant -> address owner -> data owner.
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int NO_OF_MASTERS  = 4,
    parameter int M_BITS         = $clog2(NO_OF_MASTERS),
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0] HLOCK,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HBURST,
    input  logic                     HREADY,
    output logic [NO_OF_MASTERS-1:0] HGRANT,
    output logic [M_BITS-1:0]        HMASTER,
    output logic [M_BITS-1:0]        HMASTER_D,
    output logic                     HMASTLOCK
);

    localparam logic [NO_OF_MASTERS-1:0] DEF_GNT = NO_OF_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [M_BITS-1:0]        DEF_IDX = M_BITS'(DEFAULT_MASTER);

    logic [NO_OF_MASTERS-1:0] grant_q, grant_d;
    logic [M_BITS-1:0]        master_q, master_dp_q, rr_q, rr_d;
    logic [M_BITS-1:0]        gnt_idx, pick_idx, sel;
    logic                     mastlock_q, pick_found;
    logic                     idle_acc, last_seq, burst_start, lock_ok, arb_ok;
    logic [3:0]               beats_q, beats_d;
    htrans_e                  trans;

    assign trans = htrans_e'(HTRANS);

    rr_priority_picker #(.N(NO_OF_MASTERS), .M_BITS(M_BITS)) u_pick (
        .req   (HBUSREQ),
        .ptr   (rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NO_OF_MASTERS; i++)
            if (grant_q[i]) gnt_idx = M_BITS'(i);
    end

    // A burst's own NONSEQ edge must not hand the bus away before its SEQ beats
    assign idle_acc    = HREADY && trans == IDLE;
    assign last_seq    = HREADY && trans == SEQ && beats_q == 4'd1;
    assign burst_start = HREADY && trans == NONSEQ && burst_len_m1(HBURST) != 4'd0;
    assign lock_ok     = !HLOCK[master_q] || idle_acc;
    assign arb_ok      = (beats_q == 4'd0 || last_seq || idle_acc) && !burst_start && lock_ok;
    assign sel         = pick_found ? pick_idx : DEF_IDX;

    always_comb begin
        beats_d = trans == NONSEQ ? burst_len_m1(HBURST) :
                  trans == IDLE   ? 4'd0 :
                  (trans == SEQ && beats_q != 4'd0) ? beats_q - 4'd1 : beats_q;
        grant_d = arb_ok ? NO_OF_MASTERS'(1) << sel : grant_q;
        rr_d    = (arb_ok && sel != master_q) ? sel : rr_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q     <= DEF_GNT;
            master_q    <= DEF_IDX;
            master_dp_q <= DEF_IDX;
            mastlock_q  <= 1'b0;
            beats_q     <= 4'd0;
            rr_q        <= '0;
        end else if (HREADY) begin
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            beats_q     <= beats_d;
            master_q    <= gnt_idx;
            mastlock_q  <= HLOCK[gnt_idx];
            master_dp_q <= master_q;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTER_D = master_dp_q;
    assign HMASTLOCK = mastlock_q;

endmodule
